// File: rtl/text_console_pkg.sv
// Shared timing constants, control codes and types for the text console.
package text_console_pkg;

  localparam logic [9:0] H_TOTAL        = 10'd800;
  localparam logic [9:0] H_SYNC_START   = 10'd16;
  localparam logic [9:0] H_SYNC_END     = 10'd112;
  localparam logic [9:0] H_ACTIVE_START = 10'd160;
  localparam logic [9:0] V_TOTAL        = 10'd525;
  localparam logic [9:0] V_ACTIVE       = 10'd480;
  localparam logic [9:0] V_SYNC_START   = 10'd490;
  localparam logic [9:0] V_SYNC_END     = 10'd492;

  localparam int PIPE_LAT = 3;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TILDE = 8'h7E;

  typedef enum logic [1:0] {IDLE, CLR_ROW, CLR_ALL} state_t;

  // Per-pixel flags carried alongside the RAM/ROM lookups.
  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic       cpix;
    logic       inv;
    logic [2:0] bsel;
  } pix_t;

  // Multiply by a constant as a sum of shifted copies; k is elaborated away.
  function automatic logic [15:0] mul_const(input logic [15:0] a, input logic [15:0] k);
    logic [15:0] acc;
    acc = '0;
    for (int i = 0; i < 16; i++)
      if (k[i]) acc = acc + (a << i);
    return acc;
  endfunction

endpackage

// File: rtl/character_generator.sv
// 8x8 glyph ROM with a registered output; MSB of each row is the leftmost pixel.
module character_generator (
  input  logic       pxlclk,
  input  logic [6:0] ascii,
  input  logic [2:0] row,
  output logic [7:0] dout
);

  logic [7:0] g;

  always_comb begin
    g = 8'h00;
    case (ascii)
      7'h41: case (row)
        3'd0: g = 8'h18;
        3'd1: g = 8'h3C;
        3'd2, 3'd3, 3'd5, 3'd6: g = 8'h66;
        3'd4: g = 8'h7E;
        default: g = 8'h00;
      endcase
      7'h58: case (row)
        3'd0, 3'd1, 3'd5, 3'd6: g = 8'h66;
        3'd2, 3'd4: g = 8'h3C;
        3'd3: g = 8'h18;
        default: g = 8'h00;
      endcase
      // Remaining visible glyphs render as a solid block; space stays blank.
      default: if (ascii > 7'h20 && ascii < 7'h7F && row != 3'd0 && row != 3'd7) g = 8'h7E;
    endcase
  end

  always_ff @(posedge pxlclk) dout <= g;

endmodule

// File: rtl/console_char_ram.sv
// Simple dual-port character buffer: one write port, one registered read port.
module console_char_ram #(
  parameter int DEPTH = 4800,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          pxlclk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge pxlclk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/text_console.sv
// 640x480 character-cell renderer with a terminal-style byte input port.
// Define TEXT_CONSOLE_CURSOR_EN to blink the cursor cell (FG/BG swap).
module text_console
  import text_console_pkg::*;
#(
  parameter int          COLS   = 80,
  parameter int          ROWS   = 60,
  parameter logic [23:0] FG_RGB = 24'hFFFFFF,
  parameter logic [23:0] BG_RGB = 24'h000000
) (
  input  logic                    pxlclk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              in_data,
  output logic [7:0]              r,
  output logic [7:0]              g,
  output logic [7:0]              b,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    dena,
  output logic [$clog2(COLS)-1:0] cursor_col,
  output logic [$clog2(ROWS)-1:0] cursor_row
);

  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(CELLS);
  localparam logic [9:0] X_END = 10'(COLS * 8);
  localparam logic [9:0] Y_END = 10'(ROWS * 8);

  logic [9:0]    h, v, x;
  logic [AW-1:0] rd_addr, cur_addr, clr_addr, wr_addr, clr_cnt;
  logic [7:0]    ram_q, glyph, wr_data;
  logic [2:0]    row_d1;
  logic          hi_d2, cur_hit, wr_en, pix_on, fg_sel;
  pix_t          p0, last;
  pix_t          pipe_q [1:PIPE_LAT-1];
  state_t        state;
  logic          accept, printable, at_last, do_nl;
  logic [RW-1:0] next_row;

  always_ff @(posedge pxlclk)
    if (!rstn) begin
      h <= '0;
      v <= '0;
    end else if (h == H_TOTAL - 10'd1) begin
      h <= '0;
      v <= (v == V_TOTAL - 10'd1) ? '0 : v + 10'd1;
    end else begin
      h <= h + 10'd1;
    end

  assign x = h - H_ACTIVE_START;

  always_comb begin
    p0      = '0;
    p0.hs   = (h >= H_SYNC_START) && (h < H_SYNC_END);
    p0.vs   = (v >= V_SYNC_START) && (v < V_SYNC_END);
    p0.de   = (h >= H_ACTIVE_START) && (v < V_ACTIVE);
    p0.cpix = (x < X_END) && (v < Y_END);
    p0.inv  = cur_hit;
    p0.bsel = x[2:0];
  end

  assign rd_addr = AW'(mul_const(16'(v[9:3]), 16'(COLS)) + 16'(x[9:3]));

`ifdef TEXT_CONSOLE_CURSOR_EN
  logic [5:0] frame_cnt;
  always_ff @(posedge pxlclk)
    if (!rstn) frame_cnt <= '0;
    else if (v == V_ACTIVE && h == '0) frame_cnt <= frame_cnt + 6'd1;
  assign cur_hit = frame_cnt[5] && (x[9:3] == 7'(cursor_col)) && (v[9:3] == 7'(cursor_row));
`else
  assign cur_hit = 1'b0;
`endif

  console_char_ram #(.DEPTH(CELLS), .AW(AW)) u_ram (
    .pxlclk, .we(wr_en), .waddr(wr_addr), .wdata(wr_data), .raddr(rd_addr), .rdata(ram_q)
  );

  character_generator u_cg (.pxlclk, .ascii(ram_q[6:0]), .row(row_d1), .dout(glyph));

  // Codes with bit 7 set are never written, but render blank if they appear.
  assign last   = pipe_q[PIPE_LAT-1];
  assign pix_on = glyph[3'd7 - last.bsel] & ~hi_d2;
  assign fg_sel = last.cpix & (pix_on ^ last.inv);

  always_ff @(posedge pxlclk)
    if (!rstn) begin
      for (int i = 1; i < PIPE_LAT; i++) pipe_q[i] <= '0;
      row_d1      <= '0;
      hi_d2       <= 1'b0;
      {r, g, b}   <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      dena        <= 1'b0;
    end else begin
      pipe_q[1] <= p0;
      for (int i = 2; i < PIPE_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      row_d1    <= v[2:0];
      hi_d2     <= ram_q[7];
      hsync     <= last.hs;
      vsync     <= last.vs;
      dena      <= last.de;
      {r, g, b} <= !last.de ? 24'h0 : (fg_sel ? FG_RGB : BG_RGB);
    end

  assign in_ready  = (state == IDLE) && rstn;
  assign accept    = in_valid && in_ready;
  assign printable = (in_data >= CH_SPACE) && (in_data <= CH_TILDE);
  assign at_last   = cursor_col == CW'(COLS - 1);
  assign do_nl     = (printable && at_last) || (in_data == CH_LF);
  assign next_row  = (cursor_row == RW'(ROWS - 1)) ? '0 : cursor_row + RW'(1);
  assign cur_addr  = AW'(mul_const(16'(cursor_row), 16'(COLS)) + 16'(cursor_col));
  assign clr_addr  = AW'(mul_const(16'(cursor_row), 16'(COLS)) + 16'(clr_cnt));

  always_ff @(posedge pxlclk)
    if (!rstn) begin
      state      <= CLR_ALL;
      clr_cnt    <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (printable) begin
            wr_en   <= 1'b1;
            wr_addr <= cur_addr;
            wr_data <= in_data;
          end
          if (do_nl) begin
            cursor_col <= '0;
            cursor_row <= next_row;
            clr_cnt    <= '0;
            state      <= CLR_ROW;
          end else if (printable) begin
            cursor_col <= cursor_col + CW'(1);
          end else if (in_data == CH_CR) begin
            cursor_col <= '0;
          end else if (in_data == CH_BS) begin
            if (cursor_col != '0) cursor_col <= cursor_col - CW'(1);
          end else if (in_data == CH_FF) begin
            cursor_col <= '0;
            cursor_row <= '0;
            clr_cnt    <= '0;
            state      <= CLR_ALL;
          end
        end
        CLR_ROW: begin
          wr_en   <= 1'b1;
          wr_addr <= clr_addr;
          wr_data <= CH_SPACE;
          clr_cnt <= clr_cnt + AW'(1);
          if (clr_cnt == AW'(COLS - 1)) state <= IDLE;
        end
        CLR_ALL: begin
          wr_en   <= 1'b1;
          wr_addr <= clr_cnt;
          wr_data <= CH_SPACE;
          clr_cnt <= clr_cnt + AW'(1);
          if (clr_cnt == AW'(CELLS - 1)) state <= IDLE;
        end
        default: begin
          clr_cnt <= '0;
          state   <= CLR_ALL;
        end
      endcase
    end

endmodule

// File: tb/tb_text_console.sv
// Directed bench: timed pixel/sync vectors plus cursor and clear sequences.
module tb_text_console;
  localparam int COLS = 80;
  localparam int ROWS = 60;
  localparam logic [23:0] FG = 24'hF0A050;
  localparam logic [23:0] BG = 24'h102030;

  logic pxlclk = 1'b0;
  logic rstn = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready;
  logic [7:0] r, g, b;
  logic hsync, vsync, dena;
  logic [$clog2(COLS)-1:0] cursor_col;
  logic [$clog2(ROWS)-1:0] cursor_row;

  always #5 pxlclk = ~pxlclk;

  text_console #(.COLS(COLS), .ROWS(ROWS), .FG_RGB(FG), .BG_RGB(BG)) dut (
    .pxlclk(pxlclk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync),
    .dena(dena), .cursor_col(cursor_col), .cursor_row(cursor_row)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit started = 1'b0;
  bit tbl_done = 1'b0;

  // Pixel-clock count since reset release; output at cyc=n shows counter state n-3.
  always @(posedge pxlclk) cyc <= rstn ? cyc + 1 : 0;

  typedef struct {
    int          n;
    logic        hs;
    logic        de;
    logic        chk;
    logic [23:0] rgb;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(int n, logic hs, logic de, logic chk, logic [23:0] rgb);
    vec_t e;
    e.n = n; e.hs = hs; e.de = de; e.chk = chk; e.rgb = rgb;
    tbl.push_back(e);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic send(input logic [7:0] d);
    int t;
    t = 0;
    @(negedge pxlclk);
    while (!in_ready && t < 20000) begin
      @(negedge pxlclk);
      t++;
    end
    if (t >= 20000) check("send_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge pxlclk);
    in_valid = 1'b0;
  endtask

  task automatic count_low(output int c);
    c = 0;
    while (!in_ready && c < 20000) begin
      c++;
      @(negedge pxlclk);
    end
  endtask

  task automatic check_cursor(input string name, input int col, input int row);
    check({name, "_col"}, cursor_col, col);
    check({name, "_row"}, cursor_row, row);
  endtask

  initial begin : table_proc
    wait (started);
    foreach (tbl[i]) begin
      int t;
      t = 0;
      while (cyc < tbl[i].n && t < 30000) begin
        @(posedge pxlclk);
        #1;
        t++;
      end
      if (cyc != tbl[i].n) begin
        check($sformatf("vec%0d_reach", i), cyc, tbl[i].n);
      end else begin
        check($sformatf("vec%0d_hsync", i), hsync, tbl[i].hs);
        check($sformatf("vec%0d_vsync", i), vsync, 0);
        check($sformatf("vec%0d_dena", i), dena, tbl[i].de);
        if (tbl[i].chk) check($sformatf("vec%0d_rgb", i), {r, g, b}, tbl[i].rgb);
      end
    end
    tbl_done = 1'b1;
  end

  initial begin : main_proc
    int c;
    int t;
    // n, hsync, dena, check rgb, rgb
    add(18, 0, 0, 0, 0);      add(19, 1, 0, 0, 0);      add(114, 1, 0, 0, 0);
    add(115, 0, 0, 0, 0);     add(162, 0, 0, 0, 0);     add(163, 0, 1, 0, 0);
    add(802, 0, 1, 0, 0);     add(803, 0, 0, 1, 0);     add(819, 1, 0, 1, 0);
    add(4803, 0, 0, 1, 0);
    add(4963, 0, 1, 1, BG);   add(4964, 0, 1, 1, FG);   add(4966, 0, 1, 1, BG);
    add(4968, 0, 1, 1, FG);   add(4971, 0, 1, 1, BG);   add(5764, 0, 1, 1, BG);
    add(6565, 0, 1, 1, BG);   add(6566, 0, 1, 1, FG);   add(8164, 0, 1, 1, FG);
    add(8166, 0, 1, 1, BG);   add(9763, 0, 1, 1, BG);   add(9764, 0, 1, 1, FG);
    add(13763, 0, 1, 1, BG);  add(13764, 0, 1, 1, FG);  add(13804, 0, 1, 1, FG);
    add(15366, 0, 1, 1, FG);  add(15444, 0, 1, 1, BG);  add(15998, 0, 1, 1, FG);
    add(20363, 0, 1, 1, BG);

    repeat (5) @(negedge pxlclk);
    check("rst_rgb", {r, g, b}, 0);
    check("rst_hsync", hsync, 0);
    check("rst_vsync", vsync, 0);
    check("rst_dena", dena, 0);
    check("rst_in_ready", in_ready, 0);
    check_cursor("rst", 0, 0);

    rstn = 1'b1;
    started = 1'b1;
    count_low(c);
    check("clr_all_release", c, 4800);

    send(8'h41);  check_cursor("a0", 1, 0);
    send(8'h0A);  check_cursor("lf1", 0, 1);
    count_low(c); check("clr_row_lf", c, 80);
    send(8'h41);  check_cursor("a1", 1, 1);
    send(8'h0A);  check_cursor("lf2", 0, 2);
    repeat (79) send(8'h58);
    check_cursor("x79", 79, 2);
    check("x79_ready", in_ready, 1);
    send(8'h58);  check_cursor("x80_wrap", 0, 3);
    count_low(c); check("clr_row_wrap", c, 80);

    send(8'h08);  check_cursor("bs_col0", 0, 3);
    send(8'h42);
    send(8'h43);  check_cursor("bc", 2, 3);
    send(8'h08);  check_cursor("bs", 1, 3);
    send(8'h0D);  check_cursor("cr", 0, 3);
    send(8'h01);  check_cursor("ignored", 0, 3);
    check("ignored_ready", in_ready, 1);

    repeat (56) send(8'h0A);
    check_cursor("row59", 0, 59);
    send(8'h0A);  check_cursor("row_wrap", 0, 0);
    count_low(c); check("clr_row0", c, 80);

    t = 0;
    while (!tbl_done && t < 40000) begin
      @(posedge pxlclk);
      t++;
    end
    check("table_done", tbl_done, 1);

    send(8'h5A);  check_cursor("z", 1, 0);
    send(8'h0C);  check_cursor("ff", 0, 0);
    count_low(c); check("clr_all_ff", c, 4800);

    send(8'h0A);  check_cursor("lf_abort", 0, 1);
    repeat (5) @(negedge pxlclk);
    check("mid_clr_ready", in_ready, 0);
    rstn = 1'b0;
    @(negedge pxlclk);
    check("abort_rgb", {r, g, b}, 0);
    check("abort_hsync", hsync, 0);
    check("abort_dena", dena, 0);
    check_cursor("abort", 0, 0);
    rstn = 1'b1;
    count_low(c);
    check("clr_all_abort", c, 4800);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
